multicycle_ctrl: RTL and testbench

Main control unit for the multicycle MIPS-subset datapath: the producer of the ALU's 3-bit control code and the consumer of its zero flag. A Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback steps. It drives the datapath enables and mux selects. A nested ALU decoder maps opcode/funct to the ALU control encoding (000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT).

---
 rtl/multicycle_ctrl_pkg.sv | 53 +++++
 rtl/multicycle_ctrl_alu_decoder.sv | 28 ++
 rtl/multicycle_ctrl.sv | 130 +++++++++++++
 tb/tb_multicycle_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset control unit:
// FSM states, opcode/funct values, ALU control and aluop codes.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    function automatic logic funct_ok(input logic [5:0] f);
        logic ok;
        case (f)
            F_ADD, F_SUB, F_AND,
            F_OR, F_SLT: ok = 1'b1;
            default:     ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational ALU decoder: aluop and R-type funct to the
// 3-bit ALU control code.
module alu_decoder
    import multicycle_ctrl_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alu_ctrl
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    F_SUB:   alu_ctrl = ALU_SUB;
                    F_AND:   alu_ctrl = ALU_AND;
                    F_OR:    alu_ctrl = ALU_OR;
                    F_SLT:   alu_ctrl = ALU_SLT;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS-subset datapath;
// drives enables, mux selects and the ALU decoder.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [2:0] alu_ctrl,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       iord,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t     state_q;
    state_t     state_d;
    logic [1:0] aluop;
    logic       pc_write;
    logic       branch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = S_FETCH;
        aluop      = ALUOP_ADD;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        pc_write   = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                alu_src_b = 2'b01;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    OP_RTYPE: begin
                        if (funct_ok(funct)) state_d = S_EXEC;
                        else illegal_op = 1'b1;
                    end
                    default: illegal_op = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                // anything but lw/sw here means op moved; abandon safely
                if (op == OP_LW)      state_d = S_MEMRD;
                else if (op == OP_SW) state_d = S_MEMWR;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                aluop     = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                aluop     = ALUOP_SUB;
                branch    = 1'b1;
                pc_src    = 2'b01;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
            end
            default: state_d = S_FETCH;
        endcase
    end

    alu_decoder u_alu_dec (
        .aluop    (aluop),
        .funct    (funct),
        .alu_ctrl (alu_ctrl)
    );

    assign pc_en = pc_write | (branch & zero);
    assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes expected
// output snapshots, a negedge monitor pops and compares them.
module tb_multicycle_ctrl;

    logic       clk;
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic [2:0] alu_ctrl;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       iord;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal_op;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [19:0] v;
        string       tag;
    } exp_t;

    exp_t q[$];

    multicycle_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .alu_ctrl   (alu_ctrl),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_src     (pc_src),
        .pc_en      (pc_en),
        .iord       (iord),
        .ir_write   (ir_write),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .illegal_op (illegal_op),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {state, alu_ctrl, src_a, src_b, pc_src, pc_en, iord,
    //  ir_write, mem_write, reg_write, reg_dst, mem_to_reg, illegal}
    function automatic logic [19:0] pack(
        input logic [3:0] st, input logic [2:0] alu,
        input logic sa, input logic [1:0] sb,
        input logic [1:0] ps, input logic pe, input logic io,
        input logic irw, input logic mw, input logic rw,
        input logic rd, input logic m2r, input logic ill);
        return {st, alu, sa, sb, ps, pe, io,
                irw, mw, rw, rd, m2r, ill};
    endfunction

    function automatic logic [19:0] ref_out(
        input logic [3:0] st, input logic [2:0] alu,
        input logic z, input logic ill);
        logic [19:0] r;
        case (st)
            4'd0:  r = pack(st, 3'b010, 0, 2'b01, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0);
            4'd1:  r = pack(st, 3'b010, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, ill);
            4'd2:  r = pack(st, 3'b010, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
            4'd3:  r = pack(st, 3'b010, 0, 2'b00, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0);
            4'd4:  r = pack(st, 3'b010, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0);
            4'd5:  r = pack(st, 3'b010, 0, 2'b00, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0);
            4'd6:  r = pack(st, alu,    1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
            4'd7:  r = pack(st, 3'b010, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0);
            4'd8:  r = pack(st, 3'b110, 1, 2'b00, 2'b01, z, 0, 0, 0, 0, 0, 0, 0);
            4'd9:  r = pack(st, 3'b010, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
            4'd10: r = pack(st, 3'b010, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0);
            4'd11: r = pack(st, 3'b010, 0, 2'b00, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0);
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [19:0] dut_out();
        return pack(state, alu_ctrl, alu_src_a, alu_src_b,
                    pc_src, pc_en, iord, ir_write, mem_write,
                    reg_write, reg_dst, mem_to_reg, illegal_op);
    endfunction

    task automatic compare(input string tag, input logic [19:0] e);
        logic [19:0] a;
        a = dut_out();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %05h want %05h", tag, a, e);
        end
    endtask

    // one clock: drive zero, push expected for the state just entered
    task automatic cyc(input logic [3:0] st, input logic [2:0] alu,
                       input logic z, input logic ill, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        zero  = z;
        e.v   = ref_out(st, alu, z, ill);
        e.tag = $sformatf("%s_s%0d", tag, st);
        q.push_back(e);
    endtask

    task automatic issue(input logic [5:0] o, input logic [5:0] f);
        op    = o;
        funct = f;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            compare(e.tag, e.v);
        end
    end

    logic [5:0] fs [5];
    logic [2:0] as [5];

    initial begin
        fs[0] = 6'b100000; as[0] = 3'b010;
        fs[1] = 6'b100010; as[1] = 3'b110;
        fs[2] = 6'b100100; as[2] = 3'b000;
        fs[3] = 6'b100101; as[3] = 3'b001;
        fs[4] = 6'b101010; as[4] = 3'b111;

        rst_n = 1'b0;
        op    = 6'b000000;
        funct = 6'b000000;
        zero  = 1'b0;

        cyc(0, 0, 0, 0, "rst");
        cyc(0, 0, 1, 0, "rst");
        issue(6'b100011, 6'b000000);
        #2 rst_n = 1'b1;

        // lw; op corrupted in MEMRD must not matter
        cyc(1, 0, 0, 0, "lw");
        cyc(2, 0, 0, 0, "lw");
        cyc(3, 0, 1, 0, "lw");
        op = 6'b111111;
        cyc(4, 0, 0, 0, "lw");
        cyc(0, 0, 0, 0, "lw");

        issue(6'b101011, 6'b000000);
        cyc(1, 0, 0, 0, "sw");
        cyc(2, 0, 0, 0, "sw");
        cyc(5, 0, 0, 0, "sw");
        cyc(0, 0, 0, 0, "sw");

        for (int i = 0; i < 5; i++) begin
            issue(6'b000000, fs[i]);
            cyc(1, 0, 0, 0, "rt");
            cyc(6, as[i], 1, 0, "rt");
            cyc(7, 0, 1, 0, "rt");
            cyc(0, 0, 0, 0, "rt");
        end

        issue(6'b000100, 6'b000000);
        cyc(1, 0, 0, 0, "beq_t");
        cyc(8, 0, 1, 0, "beq_t");
        cyc(0, 0, 0, 0, "beq_t");

        issue(6'b000100, 6'b000000);
        cyc(1, 0, 1, 0, "beq_nt");
        cyc(8, 0, 0, 0, "beq_nt");
        cyc(0, 0, 0, 0, "beq_nt");

        issue(6'b000010, 6'b000000);
        cyc(1, 0, 0, 0, "j");
        cyc(11, 0, 0, 0, "j");
        cyc(0, 0, 0, 0, "j");

        issue(6'b001000, 6'b000000);
        cyc(1, 0, 0, 0, "addi");
        cyc(9, 0, 0, 0, "addi");
        cyc(10, 0, 0, 0, "addi");
        cyc(0, 0, 0, 0, "addi");

        issue(6'b111111, 6'b000000);
        cyc(1, 0, 0, 1, "ill_op");
        cyc(0, 0, 0, 0, "ill_op");

        issue(6'b000000, 6'b000111);
        cyc(1, 0, 0, 1, "ill_fn");
        cyc(0, 0, 0, 0, "ill_fn");

        // reset asserted mid-MEMRD
        issue(6'b100011, 6'b000000);
        cyc(1, 0, 0, 0, "lw2");
        cyc(2, 0, 0, 0, "lw2");
        cyc(3, 0, 0, 0, "lw2");
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 compare("rst_async", ref_out(0, 0, 0, 0));
        cyc(0, 0, 0, 0, "rst_hold");
        issue(6'b000010, 6'b000000);
        #2 rst_n = 1'b1;
        cyc(1, 0, 0, 0, "j2");
        cyc(11, 0, 0, 0, "j2");
        cyc(0, 0, 0, 0, "j2");

        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
